clock_ratio_ctrl: RTL and testbench
===================================

// Module: clock_ratio_ctrl
// PURPOSE
//  Clock-generation block of the management SoC clocking path.
//  - Derives core_clk and user_clk from the fast input clock with independent programmable integer dividers.
//  - Supports glitch-free ratio changes and per-output enables.
//  - Optional edge-count monitor measures the core/user frequency ratio for firmware self-test.
// PARAMETERS
//  DIV_W   3   divider field width; ratio N = field + 2 (2..9)
//  MON_W   16  monitor edge-counter width (saturating)
//  WIN_W   16  monitor window-length width, in input clock cycles
// PORTS
//  clock         in   1      input clock; all logic on rising edge
//  resetb        in   1      asynchronous active-low reset
//  core_div      in   DIV_W  core divider select, N_core = core_div + 2
//  user_div      in   DIV_W  user divider select, N_user = user_div + 2
//  core_en       in   1      core_clk run enable
//  user_en       in   1      user_clk run enable
//  core_clk      out  1      divided core clock, registered
//  user_clk      out  1      divided user clock, registered
//  mon_start     in   1      pulse: start monitor window (CLK_MON_EN only)
//  mon_window    in   WIN_W  window length W in clock cycles (CLK_MON_EN only)
//  mon_busy      out  1      window in progress (CLK_MON_EN only)
//  mon_done      out  1      1-cycle pulse at window end (CLK_MON_EN only)
//  mon_core_cnt  out  MON_W  core_clk rising edges in last window (CLK_MON_EN only)
//  mon_user_cnt  out  MON_W  user_clk rising edges in last window (CLK_MON_EN only)
// BEHAVIOUR
//  - Reset: counters 0, core_clk = user_clk = 0, active ratios load from *_div; monitor idle, counts 0.
//  - Divider channels (core and user identical): counter cnt runs 0..N-1 and wraps.
//  - Output: clk_out <= (cnt_next < N/2) (integer divide).
//    N=2: 50% duty. N=3: high 1 of 3 cycles.
//    Rising edge occurs on the cycle cnt becomes 0, so exactly one rising edge per N input cycles.
//  - Ratio change: *_div is sampled into the active N only when cnt wraps to 0. No runt pulses.
//    *_div changes mid-period are ignored until the wrap.
//  - Enable: sampled at wrap.
//    en=0: cnt held at 0, output held low. Any high phase already in progress completes first.
//    en=1: counting resumes from 0; the first rising edge follows on the next clock.
//  - The two channels are independent. No phase relationship between them is guaranteed after a ratio change.
// CONFIGURATION
//  CLK_MON_EN defined: monitor compiled in.
//   - mon_start while idle clears both counts, sets mon_busy, and loads W.
//   - For the next W cycles, counts 0->1 transitions of each registered output, saturating at 2^MON_W-1.
//   - Afterwards: mon_busy=0, mon_done pulses for 1 cycle, counts held until next start.
//   - mon_start while busy is ignored. W=0 yields an immediate done with zero counts.
//  CLK_MON_EN undefined: monitor ports absent, no monitor logic.
// TESTING
//  1. Reset released, core_div=user_div=0, both en=1:
//     -> both clocks toggle every cycle.
//     -> W=256 window gives core_cnt=128, user_cnt=128.
//  2. core_div=user_div=1 (N=3), W=384 -> both counts 128. Duty: 1 high, 2 low.
//  3. core_div=4 (N=6), user_div=0 (N=2), W=768 -> core_cnt=128, user_cnt=384 (3:1).
//  4. core_div=6 (N=8), user_div=0, W=1024 -> core_cnt=128, user_cnt=512 (4:1).
//  5. Change core_div 0->6 mid-period -> no output pulse shorter than 1 input cycle.
//     New period takes effect at the next wrap.
//  6. core_en=0 -> core_clk low within N cycles and stays low; counts 0 in the window.
//     resetb low mid-window -> outputs and counts 0 immediately.

Source files
------------

// File: rtl/clock_ratio_ctrl.sv
// clock_ratio_ctrl: two independent glitch-free integer clock dividers; define CLK_MON_EN to add the edge-count ratio monitor.
module clock_ratio_div #(
    parameter int DIV_W = 3
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             clk_out
);
    localparam int NW = DIV_W + 1;
    logic [NW-1:0] cnt_q, n_q, cnt_inc;
    logic          run_q, load;
    assign cnt_inc = cnt_q + 1'b1;
    // Ratio and enable are only taken at a period boundary, or while parked at 0.
    assign load = !run_q || cnt_inc == n_q;
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q   <= '0;
            n_q     <= NW'(2);
            run_q   <= 1'b0;
            clk_out <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            n_q     <= {1'b0, div} + NW'(2);
            run_q   <= en;
            clk_out <= en;
        end else begin
            cnt_q   <= cnt_inc;
            clk_out <= cnt_inc < (n_q >> 1);
        end
    end
endmodule

module clock_ratio_ctrl #(
    parameter int DIV_W = 3,
    parameter int MON_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [DIV_W-1:0] core_div,
    input  logic [DIV_W-1:0] user_div,
    input  logic             core_en,
    input  logic             user_en,
    output logic             core_clk,
    output logic             user_clk
`ifdef CLK_MON_EN
    ,
    input  logic             mon_start,
    input  logic [WIN_W-1:0] mon_window,
    output logic             mon_busy,
    output logic             mon_done,
    output logic [MON_W-1:0] mon_core_cnt,
    output logic [MON_W-1:0] mon_user_cnt
`endif
);
    clock_ratio_div #(.DIV_W(DIV_W)) u_core (
        .clock(clock), .resetb(resetb), .div(core_div), .en(core_en), .clk_out(core_clk)
    );
    clock_ratio_div #(.DIV_W(DIV_W)) u_user (
        .clock(clock), .resetb(resetb), .div(user_div), .en(user_en), .clk_out(user_clk)
    );
`ifdef CLK_MON_EN
    logic             core_d, user_d;
    logic [WIN_W-1:0] rem_q;
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            core_d       <= 1'b0;
            user_d       <= 1'b0;
            rem_q        <= '0;
            mon_busy     <= 1'b0;
            mon_done     <= 1'b0;
            mon_core_cnt <= '0;
            mon_user_cnt <= '0;
        end else begin
            core_d   <= core_clk;
            user_d   <= user_clk;
            mon_done <= 1'b0;
            if (!mon_busy && mon_start) begin
                mon_core_cnt <= '0;
                mon_user_cnt <= '0;
                rem_q        <= mon_window;
                mon_busy     <= mon_window != '0;
                mon_done     <= mon_window == '0;
            end else if (mon_busy) begin
                if (core_clk && !core_d && mon_core_cnt != '1) mon_core_cnt <= mon_core_cnt + 1'b1;
                if (user_clk && !user_d && mon_user_cnt != '1) mon_user_cnt <= mon_user_cnt + 1'b1;
                rem_q <= rem_q - 1'b1;
                if (rem_q == WIN_W'(1)) begin
                    mon_busy <= 1'b0;
                    mon_done <= 1'b1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_clock_ratio_ctrl.sv
// tb_clock_ratio_ctrl: directed checks of divider ratios, duty, ratio change, enable and reset; monitor checks under CLK_MON_EN.
module tb_clock_ratio_ctrl;
    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic [2:0] core_div = '0, user_div = '0;
    logic       core_en = 1'b1, user_en = 1'b1;
    logic       core_clk, user_clk;
    logic [15:0] v;
`ifdef CLK_MON_EN
    logic        mon_start = 1'b0;
    logic [15:0] mon_window = '0;
    logic        mon_busy, mon_done;
    logic [15:0] mon_core_cnt, mon_user_cnt;
`endif
    int n_vec = 0, n_err = 0;

    always #5 clock = ~clock;

    clock_ratio_ctrl dut (
        .clock(clock), .resetb(resetb),
        .core_div(core_div), .user_div(user_div),
        .core_en(core_en), .user_en(user_en),
        .core_clk(core_clk), .user_clk(user_clk)
`ifdef CLK_MON_EN
        , .mon_start(mon_start), .mon_window(mon_window), .mon_busy(mon_busy),
        .mon_done(mon_done), .mon_core_cnt(mon_core_cnt), .mon_user_cnt(mon_user_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts bench-observed rising edges and high cycles over w cycles; cross-checks the monitor when present.
    task automatic window(input string tag, input int w, input int ec, input int hc, input int eu, input int hu);
        int   ce = 0, ch = 0, ue = 0, uh = 0;
        logic pc, pu;
`ifdef CLK_MON_EN
        int t;
        mon_window = w[15:0];
        mon_start = 1'b1;
`endif
        @(negedge clock);
`ifdef CLK_MON_EN
        mon_start = 1'b0;
`endif
        pc = core_clk;
        pu = user_clk;
        for (int k = 0; k < w; k++) begin
            @(negedge clock);
            ce += int'(core_clk & ~pc);
            ue += int'(user_clk & ~pu);
            ch += int'(core_clk);
            uh += int'(user_clk);
            pc = core_clk;
            pu = user_clk;
        end
        check({tag, "_core_edges"}, ce, ec);
        check({tag, "_core_high"}, ch, hc);
        check({tag, "_user_edges"}, ue, eu);
        check({tag, "_user_high"}, uh, hu);
`ifdef CLK_MON_EN
        for (t = 0; t < 8 && !mon_done; t++) @(negedge clock);
        check({tag, "_mon_done"}, mon_done, 1);
        check({tag, "_mon_busy"}, mon_busy, 0);
        check({tag, "_mon_core"}, mon_core_cnt, ec);
        check({tag, "_mon_user"}, mon_user_cnt, eu);
`endif
    endtask

    task automatic sync_core_rise();
        logic p;
        bit   f = 1'b0;
        p = core_clk;
        for (int k = 0; k < 20 && !f; k++) begin
            @(negedge clock);
            f = core_clk && !p;
            p = core_clk;
        end
        check("sync_core_rise", f, 1);
    endtask

    task automatic grab(input int n, output logic [15:0] q);
        q = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            q = {q[14:0], core_clk};
        end
    endtask

    initial begin
        #12;
        check("rst_core_clk", core_clk, 0);
        check("rst_user_clk", user_clk, 0);
`ifdef CLK_MON_EN
        check("rst_mon_busy", mon_busy, 0);
        check("rst_mon_core", mon_core_cnt, 0);
        check("rst_mon_user", mon_user_cnt, 0);
`endif
        @(negedge clock);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        window("n2_n2", 256, 128, 128, 128, 128);
        core_div = 3'd1;
        user_div = 3'd1;
        repeat (12) @(negedge clock);
        window("n3_n3", 384, 128, 128, 128, 128);
        core_div = 3'd4;
        user_div = 3'd0;
        repeat (12) @(negedge clock);
        window("n6_n2", 768, 128, 384, 384, 384);
        core_div = 3'd6;
        repeat (12) @(negedge clock);
        window("n8_n2", 1024, 128, 512, 512, 512);
        core_div = 3'd0;
        repeat (20) @(negedge clock);
        sync_core_rise();
        core_div = 3'd6;
        grab(10, v);
        check("ratio_change_wave", v[9:0], 10'b0111100001);
        window("after_change", 80, 10, 40, 40, 40);
        sync_core_rise();
        core_en = 1'b0;
        grab(12, v);
        check("disable_wave", v[11:0], 12'b111000000000);
        window("disabled", 64, 0, 0, 32, 32);
        core_en = 1'b1;
        @(negedge clock);
        check("enable_first_high", core_clk, 1);
        grab(8, v);
        check("enable_wave", v[7:0], 8'b11100001);
`ifdef CLK_MON_EN
        mon_window = 16'd0;
        mon_start = 1'b1;
        @(negedge clock);
        mon_start = 1'b0;
        check("w0_done", mon_done, 1);
        check("w0_busy", mon_busy, 0);
        check("w0_core", mon_core_cnt, 0);
        check("w0_user", mon_user_cnt, 0);
        mon_window = 16'd64;
        mon_start = 1'b1;
        @(negedge clock);
        mon_start = 1'b0;
        repeat (10) @(negedge clock);
        mon_window = 16'd0;
        mon_start = 1'b1;
        @(negedge clock);
        mon_start = 1'b0;
        check("restart_busy", mon_busy, 1);
        check("restart_done", mon_done, 0);
        for (int t = 0; t < 70 && !mon_done; t++) @(negedge clock);
        check("restart_end", mon_done, 1);
        check("restart_core", mon_core_cnt, 8);
        check("restart_user", mon_user_cnt, 32);
        mon_window = 16'd256;
        mon_start = 1'b1;
        @(negedge clock);
        mon_start = 1'b0;
`endif
        repeat (20) @(negedge clock);
        #2 resetb = 1'b0;
        #1;
        check("midrst_core_clk", core_clk, 0);
        check("midrst_user_clk", user_clk, 0);
`ifdef CLK_MON_EN
        check("midrst_mon_busy", mon_busy, 0);
        check("midrst_mon_core", mon_core_cnt, 0);
        check("midrst_mon_user", mon_user_cnt, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
